// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, AXI protection
// encoding and the prefetch FIFO entry layout.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ADDR  = 2'b01,
        DATA  = 2'b10,
        DRAIN = 2'b11
    } fetch_state_t;

    localparam logic [2:0] ARPROT_INSN = 3'b100;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        fault;
    } fetch_entry_t;

    function automatic logic is_fault(input logic [1:0] resp);
        return (resp != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding fetched entries for decode; flush overrides push and pop.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           din,
    output fetch_entry_t           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // A pop in the same cycle frees the slot a push into a full FIFO uses.
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign full      = (count_r == CNT_W'(DEPTH));
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= {$bits(fetch_entry_t){1'b0}};
            end
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            count_r <= count_r + {{(CNT_W-1){1'b0}}, do_push_s} - {{(CNT_W-1){1'b0}}, do_pop_s};
        end
    end

endmodule

// File: rtl/axi_fetch.sv
// Instruction fetch stage: single-outstanding AXI4-Lite read master feeding a
// prefetch FIFO that presents {pc, insn, fault} to decode.
module axi_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddress,
    output logic [2:0]  arprot,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    output logic        insn_valid,
    input  logic        insn_ready,
    output logic [31:0] insn,
    output logic [31:0] insn_pc,
    output logic        insn_fault,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);
    import fetch_pkg::*;

    localparam int unsigned CNT_W   = $clog2(DEPTH) + 1;
    localparam logic [31:0] PC_MASK = 32'hFFFF_FFFC;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

    fetch_state_t     state_r;
    logic [31:0]      fetch_pc_r;
    logic [31:0]      araddress_r;
    logic             arvalid_r;
    logic             rready_r;
    logic             halted_r;
    logic             killed_r;

    logic             ar_hs_s;
    logic             r_hs_s;
    logic             push_s;
    logic             pop_s;
    logic             going_idle_s;
    logic             space_s;
    logic             halted_next_s;
    logic             issue_s;
    logic [31:0]      fetch_pc_next_s;
    logic [CNT_W:0]   fill_s;
    logic [CNT_W-1:0] count_s;
    logic             full_s;
    logic             empty_s;
    fetch_entry_t     push_entry_s;
    fetch_entry_t     head_s;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .pop   (pop_s),
        .flush (redirect),
        .din   (push_entry_s),
        .dout  (head_s),
        .count (count_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Handshakes, FIFO control and the next-issue decision; space is judged
    // on occupancy after this edge so a fetch can launch on the R handshake.
    always_comb begin
        ar_hs_s      = arvalid_r & arready;
        r_hs_s       = rready_r & rvalid;
        push_s       = (state_r == DATA) & r_hs_s & ~redirect;
        pop_s        = ~empty_s & insn_ready & ~redirect;
        push_entry_s = '{pc: araddress_r, insn: rdata, fault: is_fault(rresp)};
        going_idle_s = (state_r == IDLE) | (((state_r == DATA) | (state_r == DRAIN)) & r_hs_s);
        fill_s       = {1'b0, count_s} + {{CNT_W{1'b0}}, 1'b1} - {{CNT_W{1'b0}}, pop_s};
        if (redirect) begin
            space_s         = 1'b1;
            halted_next_s   = 1'b0;
            fetch_pc_next_s = redirect_pc & PC_MASK;
        end else begin
            if (push_s) begin
                space_s = (fill_s < DEPTH_C);
            end else begin
                space_s = ~full_s | pop_s;
            end
            halted_next_s = halted_r | (push_s & push_entry_s.fault);
            // A redirect seen during ADDR already replaced fetch_pc.
            if (ar_hs_s & ~killed_r) begin
                fetch_pc_next_s = fetch_pc_r + 32'd4;
            end else begin
                fetch_pc_next_s = fetch_pc_r;
            end
        end
        issue_s = going_idle_s & ~halted_next_s & space_s;
    end

    // Fetch FSM with registered AXI control outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            fetch_pc_r  <= RESET_PC & PC_MASK;
            araddress_r <= 32'h0000_0000;
            arvalid_r   <= 1'b0;
            rready_r    <= 1'b0;
            halted_r    <= 1'b0;
            killed_r    <= 1'b0;
        end else begin
            fetch_pc_r <= fetch_pc_next_s;
            halted_r   <= halted_next_s;
            if (issue_s) begin
                state_r     <= ADDR;
                arvalid_r   <= 1'b1;
                araddress_r <= fetch_pc_next_s;
                rready_r    <= 1'b0;
            end else if (going_idle_s) begin
                state_r   <= IDLE;
                arvalid_r <= 1'b0;
                rready_r  <= 1'b0;
            end else begin
                case (state_r)
                    ADDR: begin
                        if (ar_hs_s) begin
                            arvalid_r <= 1'b0;
                            rready_r  <= 1'b1;
                            killed_r  <= 1'b0;
                            state_r   <= (killed_r | redirect) ? DRAIN : DATA;
                        end else if (redirect) begin
                            killed_r <= 1'b1;
                        end
                    end
                    DATA: begin
                        if (redirect) begin
                            state_r <= DRAIN;
                        end
                    end
                    default: state_r <= state_r;
                endcase
            end
        end
    end

    assign arvalid    = arvalid_r;
    assign araddress  = araddress_r;
    assign arprot     = ARPROT_INSN;
    assign rready     = rready_r;
    assign insn_valid = ~empty_s;
    assign insn       = head_s.insn;
    assign insn_pc    = head_s.pc;
    assign insn_fault = head_s.fault;

endmodule

// File: tb/tb_axi_fetch.sv
// Directed cycle-by-cycle bench for axi_fetch with hand-computed expectations.
module tb_axi_fetch;

    logic        clk;
    logic        reset;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddress;
    logic [2:0]  arprot;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        insn_valid;
    logic        insn_ready;
    logic [31:0] insn;
    logic [31:0] insn_pc;
    logic        insn_fault;
    logic        redirect;
    logic [31:0] redirect_pc;

    int n_cmp;
    int n_err;

    axi_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .arvalid     (arvalid),
        .arready     (arready),
        .araddress   (araddress),
        .arprot      (arprot),
        .rvalid      (rvalid),
        .rready      (rready),
        .rdata       (rdata),
        .rresp       (rresp),
        .insn_valid  (insn_valid),
        .insn_ready  (insn_ready),
        .insn        (insn),
        .insn_pc     (insn_pc),
        .insn_fault  (insn_fault),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1; arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        insn_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        tick(); tick();
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_insn_valid", 32'(insn_valid), 32'd0);
        chk("rst_insn", insn, 32'h0);
        chk("rst_insn_pc", insn_pc, 32'h0);
        chk("rst_insn_fault", 32'(insn_fault), 32'd0);
        chk("arprot", 32'(arprot), 32'd4);

        // Streaming fetch, one instruction every two cycles
        reset = 1'b0; arready = 1'b1; insn_ready = 1'b1;
        tick();
        chk("e0_arvalid", 32'(arvalid), 32'd1);
        chk("e0_araddr", araddress, 32'h0);
        tick();
        chk("e1_arvalid", 32'(arvalid), 32'd0);
        chk("e1_rready", 32'(rready), 32'd1);
        rvalid = 1'b1; rdata = 32'h0000_0013;
        tick();
        chk("e2_valid", 32'(insn_valid), 32'd1);
        chk("e2_pc", insn_pc, 32'h0);
        chk("e2_insn", insn, 32'h0000_0013);
        chk("e2_araddr", araddress, 32'h4);
        chk("e2_arvalid", 32'(arvalid), 32'd1);
        rvalid = 1'b0;
        tick();
        chk("e3_valid", 32'(insn_valid), 32'd0);
        chk("e3_rready", 32'(rready), 32'd1);
        rvalid = 1'b1; rdata = 32'h0040_0093;
        tick();
        chk("e4_pc", insn_pc, 32'h4);
        chk("e4_insn", insn, 32'h0040_0093);
        chk("e4_araddr", araddress, 32'h8);
        rvalid = 1'b0;
        tick();
        chk("e5_valid", 32'(insn_valid), 32'd0);

        // Decode stalled: two fetches fill the FIFO, then fetch stops
        insn_ready = 1'b0; rvalid = 1'b1; rdata = 32'h0080_0113;
        tick();
        chk("e6_pc", insn_pc, 32'h8);
        chk("e6_araddr", araddress, 32'hC);
        chk("e6_arvalid", 32'(arvalid), 32'd1);
        rdata = 32'h00C0_0193;
        tick();
        chk("e7_rready", 32'(rready), 32'd1);
        chk("e7_arvalid", 32'(arvalid), 32'd0);
        tick();
        chk("e8_arvalid", 32'(arvalid), 32'd0);
        chk("e8_head_pc", insn_pc, 32'h8);
        rvalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_arvalid", 32'(arvalid), 32'd0);
            chk("stall_valid", 32'(insn_valid), 32'd1);
        end
        insn_ready = 1'b1;
        tick();
        chk("resume_head_pc", insn_pc, 32'hC);
        chk("resume_arvalid", 32'(arvalid), 32'd1);
        chk("resume_araddr", araddress, 32'h10);

        // Redirect while AR is stalled: address held, response dropped
        arready = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        chk("rd_flush_valid", 32'(insn_valid), 32'd0);
        chk("rd_hold_araddr", araddress, 32'h10);
        chk("rd_hold_arvalid", 32'(arvalid), 32'd1);
        redirect = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rd_stall_araddr", araddress, 32'h10);
            chk("rd_stall_arvalid", 32'(arvalid), 32'd1);
        end
        arready = 1'b1;
        tick();
        chk("drain_rready", 32'(rready), 32'd1);
        chk("drain_arvalid", 32'(arvalid), 32'd0);
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF;
        tick();
        chk("drain_dropped", 32'(insn_valid), 32'd0);
        chk("drain_next_addr", araddress, 32'h100);
        chk("drain_next_arvalid", 32'(arvalid), 32'd1);
        rvalid = 1'b0;
        tick();
        rvalid = 1'b1; rdata = 32'h1111_1111;
        tick();
        chk("rd_first_valid", 32'(insn_valid), 32'd1);
        chk("rd_first_pc", insn_pc, 32'h100);
        chk("rd_first_insn", insn, 32'h1111_1111);
        chk("rd_next_addr", araddress, 32'h104);
        rvalid = 1'b0;
        tick();
        chk("e104_rready", 32'(rready), 32'd1);

        // Redirect coincident with returning data
        rvalid = 1'b1; rdata = 32'h2222_2222; redirect = 1'b1; redirect_pc = 32'h0000_0202;
        tick();
        chk("rdr_empty", 32'(insn_valid), 32'd0);
        chk("rdr_araddr", araddress, 32'h200);
        chk("rdr_arvalid", 32'(arvalid), 32'd1);
        redirect = 1'b0; rvalid = 1'b0;
        tick();
        rvalid = 1'b1; rdata = 32'h3333_3333;
        tick();
        chk("e200_pc", insn_pc, 32'h200);
        chk("e200_insn", insn, 32'h3333_3333);
        chk("e200_next", araddress, 32'h204);
        rvalid = 1'b0;
        tick();
        chk("e204_rready", 32'(rready), 32'd1);

        // Faulting fetch halts until redirect
        rvalid = 1'b1; rresp = 2'b10; rdata = 32'h4444_4444; insn_ready = 1'b0;
        tick();
        chk("flt_valid", 32'(insn_valid), 32'd1);
        chk("flt_fault", 32'(insn_fault), 32'd1);
        chk("flt_pc", insn_pc, 32'h204);
        chk("flt_arvalid", 32'(arvalid), 32'd0);
        rvalid = 1'b0; rresp = 2'b00;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("halt_arvalid", 32'(arvalid), 32'd0);
        end
        insn_ready = 1'b1;
        tick();
        chk("halt_popped", 32'(insn_valid), 32'd0);
        chk("halt_still", 32'(arvalid), 32'd0);
        redirect = 1'b1; redirect_pc = 32'h0000_0040;
        tick();
        chk("restart_arvalid", 32'(arvalid), 32'd1);
        chk("restart_araddr", araddress, 32'h40);
        redirect = 1'b0; insn_ready = 1'b0;
        tick();
        rvalid = 1'b1; rdata = 32'h5555_5555;
        tick();
        chk("e40_pc", insn_pc, 32'h40);
        chk("e40_fault", 32'(insn_fault), 32'd0);
        chk("e44_araddr", araddress, 32'h44);
        rvalid = 1'b0; rdata = 32'h6666_6666;
        tick();
        chk("pre_rst_rready", 32'(rready), 32'd1);

        // Asynchronous reset in the middle of a transaction
        reset = 1'b1;
        #2;
        chk("mid_rst_arvalid", 32'(arvalid), 32'd0);
        chk("mid_rst_rready", 32'(rready), 32'd0);
        chk("mid_rst_valid", 32'(insn_valid), 32'd0);
        chk("mid_rst_pc", insn_pc, 32'h0);
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_arvalid", 32'(arvalid), 32'd1);
        chk("post_rst_araddr", araddress, 32'h0);
        tick();
        rvalid = 1'b1; rdata = 32'h7777_7777;
        tick();
        chk("post_rst_pc", insn_pc, 32'h0);
        chk("post_rst_insn", insn, 32'h7777_7777);
        rvalid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
